morph_window_filter: RTL and testbench

- Parametrised successor to the 3x3 morphological stage in the video pipeline.
- Applies a KSIZE x KSIZE square structuring element to a streaming active/hsync/vsync pixel stream.
- Supports erode, dilate, gradient and bypass modes; the mode is latched once per frame.
- Sits between the video-timing input and downstream stages; the sync signals pass through with a fixed, matching delay.

---
 rtl/morph_pkg.sv | 29 ++
 rtl/morph_line_buffer.sv | 22 ++
 rtl/morph_window_filter.sv | 192 +++++++++++++++++++
 tb/tb_morph_window_filter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// Shared encodings, fixed pipeline latency and helpers for the morphological window filter.
package morph_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_ERODE  = 2'b01,
        MODE_DILATE = 2'b10,
        MODE_GRAD   = 2'b11
    } mode_e;

    localparam int LAT = 3;
    localparam int Y_W = 16;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } sync_t;

    // Fill bit of the neutral element: all-ones for min, zero for max.
    function automatic logic neutral_bit(input logic is_min);
        return is_min;
    endfunction

    function automatic bit ksize_legal(input int k);
        return (k == 3) || (k == 5);
    endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// One-line delay RAM: reads the previous line's pixel at addr and overwrites it in the same cycle.
module morph_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1280,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (en) mem[addr] <= wdata;
    end

endmodule

// File: rtl/morph_window_filter.sv
// KSIZE x KSIZE erode/dilate/gradient filter on a streaming video interface, fixed 3-cycle latency.
module morph_window_filter
    import morph_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int VIDEO_WIDTH = 1280,
    parameter int KSIZE       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  in_active,
    input  logic                  in_hsync,
    input  logic                  in_vsync,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_active,
    output logic                  out_hsync,
    output logic                  out_vsync,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            cur_mode,
    output logic                  err_line_overflow
);

    localparam int XW  = $clog2(VIDEO_WIDTH + 1);
    localparam int AW  = $clog2(VIDEO_WIDTH);
    localparam int NLB = KSIZE - 1;
    localparam logic [XW-1:0] X_SAT = XW'(VIDEO_WIDTH);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    if (!ksize_legal(KSIZE)) begin : g_bad_ksize
        $error("morph_window_filter: KSIZE must be 3 or 5");
    end

    logic [XW-1:0]  x_q, x_d, x1_q, x1_d;
    logic [Y_W-1:0] y_q, y_d, y1_q, y1_d;
    logic           act_prev_q, act_prev_d, vs_prev_q, vs_prev_d;
    logic           err_q, err_d;
    mode_e          cur_mode_q, cur_mode_d, mode1_q, mode1_d, mode2_q, mode2_d;
    sync_t [LAT-1:0] sync_q, sync_d;
    pix_t [KSIZE-1:0][KSIZE-1:0] win_q, win_d;
    logic           ovf1_q, ovf1_d, ovf2_q, ovf2_d;
    pix_t           byp1_q, byp1_d, byp2_q, byp2_d;
    pix_t           mn2_q, mn2_d, mx2_q, mx2_d, out_q, out_d;

    pix_t [NLB-1:0]   lb_in, lb_out;
    pix_t [KSIZE-1:0] row_in;
    logic in_range, shift_en, vs_rise, act_fall;

    assign in_range = (x_q < X_SAT);
    assign shift_en = in_active && in_range;
    assign vs_rise  = in_vsync && !vs_prev_q;
    assign act_fall = act_prev_q && !in_active;

    // Cascade: buffer i delays by i+1 lines; row_in[KSIZE-1] is the current line.
    assign row_in[KSIZE-1] = in_data;
    for (genvar i = 0; i < NLB; i++) begin : g_lb
        if (i == 0) begin : g_first
            assign lb_in[i] = in_data;
        end else begin : g_next
            assign lb_in[i] = lb_out[i-1];
        end
        assign row_in[NLB-1-i] = lb_out[i];
        morph_line_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (VIDEO_WIDTH),
            .AW        (AW)
        ) u_lb (
            .clk  (clk),
            .en   (shift_en),
            .addr (x_q[AW-1:0]),
            .wdata(lb_in[i]),
            .rdata(lb_out[i])
        );
    end

    always_comb begin
        act_prev_d = in_active;
        vs_prev_d  = in_vsync;
        x_d        = in_active ? (in_range ? x_q + 1'b1 : x_q) : '0;
        y_d        = y_q;
        if (vs_rise)                    y_d = '0;
        else if (act_fall && y_q != '1) y_d = y_q + 1'b1;
        cur_mode_d = vs_rise ? mode_e'(mode) : cur_mode_q;
        err_d      = err_q | (in_active && !in_range);
        sync_d     = {sync_q[LAT-2:0], {in_active, in_hsync, in_vsync}};
    end

    // Stage 1: column shift registers, position tag and bypass copy.
    always_comb begin
        win_d = win_q;
        x1_d  = x1_q;
        y1_d  = y1_q;
        if (shift_en) begin
            for (int r = 0; r < KSIZE; r++) begin
                win_d[r][KSIZE-1:1] = win_q[r][KSIZE-2:0];
                win_d[r][0]         = row_in[r];
            end
            x1_d = x_q;
            y1_d = y_q;
        end
        ovf1_d  = in_active && !in_range;
        mode1_d = cur_mode_q;
        byp1_d  = in_data;
    end

    // Stage 2: masked min/max reduction; taps left of column 0 or above row 0 are neutral.
    always_comb begin
        mn2_d = {DATA_WIDTH{neutral_bit(1'b1)}};
        mx2_d = {DATA_WIDTH{neutral_bit(1'b0)}};
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                if (32'(x1_q) >= c && 32'(y1_q) >= KSIZE - 1 - r) begin
                    if (win_q[r][c] < mn2_d) mn2_d = win_q[r][c];
                    if (win_q[r][c] > mx2_d) mx2_d = win_q[r][c];
                end
            end
        end
        ovf2_d  = ovf1_q;
        mode2_d = mode1_q;
        byp2_d  = byp1_q;
    end

    // Stage 3: op select; overflowed pixels fall back to pass-through.
    always_comb begin
        out_d = '0;
        if (sync_q[LAT-2].active) begin
            if (ovf2_q) begin
                out_d = byp2_q;
            end else begin
                case (mode2_q)
                    MODE_BYPASS: out_d = byp2_q;
                    MODE_ERODE:  out_d = mn2_q;
                    MODE_DILATE: out_d = mx2_q;
                    MODE_GRAD:   out_d = mx2_q - mn2_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q        <= '0;
            y_q        <= '0;
            act_prev_q <= 1'b0;
            vs_prev_q  <= 1'b0;
            err_q      <= 1'b0;
            cur_mode_q <= MODE_BYPASS;
            sync_q     <= '0;
            win_q      <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            ovf1_q     <= 1'b0;
            mode1_q    <= MODE_BYPASS;
            byp1_q     <= '0;
            ovf2_q     <= 1'b0;
            mode2_q    <= MODE_BYPASS;
            byp2_q     <= '0;
            mn2_q      <= '0;
            mx2_q      <= '0;
            out_q      <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            act_prev_q <= act_prev_d;
            vs_prev_q  <= vs_prev_d;
            err_q      <= err_d;
            cur_mode_q <= cur_mode_d;
            sync_q     <= sync_d;
            win_q      <= win_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            ovf1_q     <= ovf1_d;
            mode1_q    <= mode1_d;
            byp1_q     <= byp1_d;
            ovf2_q     <= ovf2_d;
            mode2_q    <= mode2_d;
            byp2_q     <= byp2_d;
            mn2_q      <= mn2_d;
            mx2_q      <= mx2_d;
            out_q      <= out_d;
        end
    end

    assign out_active        = sync_q[LAT-1].active;
    assign out_hsync         = sync_q[LAT-1].hsync;
    assign out_vsync         = sync_q[LAT-1].vsync;
    assign out_data          = out_q;
    assign cur_mode          = cur_mode_q;
    assign err_line_overflow = err_q;

endmodule

// File: tb/tb_morph_window_filter.sv
// Directed frames through an 8-wide, 3x3 filter with hand-derived expected pixels per scenario.
module tb_morph_window_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       in_active = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_active, out_hsync, out_vsync, err_line_overflow;
    logic [7:0] out_data;
    logic [1:0] cur_mode;

    int checks = 0;
    int failures = 0;

    logic [7:0] img [0:7][0:15];
    logic       la [0:511], lh [0:511], lv [0:511];
    logic [7:0] ld [0:511];
    logic       oa [0:511], oh [0:511], ov [0:511], oerr [0:511];
    logic [7:0] od [0:511];
    int         lx [0:511], ly [0:511];
    int         n;

    morph_window_filter #(
        .DATA_WIDTH (8),
        .VIDEO_WIDTH(8),
        .KSIZE      (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mode             (mode),
        .in_active        (in_active),
        .in_hsync         (in_hsync),
        .in_vsync         (in_vsync),
        .in_data          (in_data),
        .out_active       (out_active),
        .out_hsync        (out_hsync),
        .out_vsync        (out_vsync),
        .out_data         (out_data),
        .cur_mode         (cur_mode),
        .err_line_overflow(err_line_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic a, input logic h, input logic v, input logic [7:0] d,
                        input int px, input int py);
        @(posedge clk);
        #1;
        in_active = a; in_hsync = h; in_vsync = v; in_data = d;
        @(negedge clk);
        la[n] = a; lh[n] = h; lv[n] = v; ld[n] = d;
        oa[n] = out_active; oh[n] = out_hsync; ov[n] = out_vsync;
        od[n] = out_data; oerr[n] = err_line_overflow;
        lx[n] = px; ly[n] = py;
        n++;
    endtask

    // Mode m0 is presented at the vsync rise; m1 replaces it after row 0.
    task automatic drive_frame(input int h, input int w, input logic [1:0] m0, input logic [1:0] m1);
        n = 0;
        mode = m0;
        step(0, 0, 1, 8'h00, -1, -1);
        step(0, 0, 1, 8'h00, -1, -1);
        step(0, 0, 0, 8'h00, -1, -1);
        step(0, 0, 0, 8'h00, -1, -1);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) step(1, 0, 0, img[y][x], x, y);
            if (y == 0) mode = m1;
            step(0, 1, 0, 8'h00, -1, -1);
            for (int b = 0; b < 3; b++) step(0, 0, 0, 8'h00, -1, -1);
        end
        for (int b = 0; b < 4; b++) step(0, 0, 0, 8'h00, -1, -1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (out_active !== 1'b0) begin failures++; $display("FAIL reset out_active got=%b exp=0", out_active); end
        if (out_hsync !== 1'b0) begin failures++; $display("FAIL reset out_hsync got=%b exp=0", out_hsync); end
        if (out_vsync !== 1'b0) begin failures++; $display("FAIL reset out_vsync got=%b exp=0", out_vsync); end
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset out_data got=%h exp=00", out_data); end
        if (cur_mode !== 2'b00) begin failures++; $display("FAIL reset cur_mode got=%b exp=00", cur_mode); end
        if (err_line_overflow !== 1'b0) begin failures++; $display("FAIL reset err got=%b exp=0", err_line_overflow); end
        rst = 1'b1;
    endtask

    task automatic test_bypass;
        for (int y = 0; y < 4; y++) for (int x = 0; x < 8; x++) img[y][x] = 8'(y * 8 + x + 1);
        drive_frame(4, 8, 2'b00, 2'b00);
        for (int k = 0; k + 3 < n; k++) begin
            logic [7:0] e;
            e = la[k] ? ld[k] : 8'h00;
            checks += 4;
            if (oa[k+3] !== la[k]) begin failures++; $display("FAIL bypass active cyc%0d got=%b exp=%b", k, oa[k+3], la[k]); end
            if (oh[k+3] !== lh[k]) begin failures++; $display("FAIL bypass hsync cyc%0d got=%b exp=%b", k, oh[k+3], lh[k]); end
            if (ov[k+3] !== lv[k]) begin failures++; $display("FAIL bypass vsync cyc%0d got=%b exp=%b", k, ov[k+3], lv[k]); end
            if (od[k+3] !== e) begin failures++; $display("FAIL bypass data cyc%0d got=%h exp=%h", k, od[k+3], e); end
        end
        checks++;
        if (cur_mode !== 2'b00) begin failures++; $display("FAIL bypass cur_mode got=%b exp=00", cur_mode); end
    endtask

    task automatic test_dilate;
        for (int y = 0; y < 4; y++) for (int x = 0; x < 8; x++) img[y][x] = 8'h00;
        img[1][3] = 8'hFF;
        drive_frame(4, 8, 2'b10, 2'b10);
        for (int k = 0; k + 3 < n; k++) if (la[k]) begin
            logic [7:0] e;
            e = (lx[k] >= 3 && lx[k] <= 5 && ly[k] >= 1 && ly[k] <= 3) ? 8'hFF : 8'h00;
            checks++;
            if (od[k+3] !== e) begin failures++; $display("FAIL dilate px(%0d,%0d) got=%h exp=%h", lx[k], ly[k], od[k+3], e); end
        end
        checks++;
        if (cur_mode !== 2'b10) begin failures++; $display("FAIL dilate cur_mode got=%b exp=10", cur_mode); end
    endtask

    task automatic test_erode;
        for (int y = 0; y < 4; y++) for (int x = 0; x < 8; x++) img[y][x] = 8'h80;
        img[2][4] = 8'h00;
        drive_frame(4, 8, 2'b01, 2'b01);
        for (int k = 0; k + 3 < n; k++) if (la[k]) begin
            logic [7:0] e;
            e = (lx[k] >= 4 && lx[k] <= 6 && ly[k] >= 2) ? 8'h00 : 8'h80;
            checks++;
            if (od[k+3] !== e) begin failures++; $display("FAIL erode px(%0d,%0d) got=%h exp=%h", lx[k], ly[k], od[k+3], e); end
        end
    endtask

    task automatic test_gradient;
        for (int y = 0; y < 4; y++) for (int x = 0; x < 8; x++) img[y][x] = (x % 2 == 1) ? 8'hFF : 8'h00;
        drive_frame(4, 8, 2'b11, 2'b11);
        for (int k = 0; k + 3 < n; k++) if (la[k]) begin
            logic [7:0] e;
            e = (lx[k] == 0) ? 8'h00 : 8'hFF;
            checks++;
            if (od[k+3] !== e) begin failures++; $display("FAIL gradient px(%0d,%0d) got=%h exp=%h", lx[k], ly[k], od[k+3], e); end
        end
    endtask

    task automatic test_mode_change;
        for (int y = 0; y < 4; y++) for (int x = 0; x < 8; x++) img[y][x] = 8'h00;
        img[1][3] = 8'hFF;
        drive_frame(4, 8, 2'b01, 2'b10);
        for (int k = 0; k + 3 < n; k++) if (la[k]) begin
            checks++;
            if (od[k+3] !== 8'h00) begin failures++; $display("FAIL modechg erode px(%0d,%0d) got=%h exp=00", lx[k], ly[k], od[k+3]); end
        end
        checks++;
        if (cur_mode !== 2'b01) begin failures++; $display("FAIL modechg cur_mode midframe got=%b exp=01", cur_mode); end
        drive_frame(4, 8, 2'b10, 2'b10);
        checks++;
        if (cur_mode !== 2'b10) begin failures++; $display("FAIL modechg cur_mode next got=%b exp=10", cur_mode); end
        for (int k = 0; k + 3 < n; k++) if (la[k]) begin
            logic [7:0] e;
            e = (lx[k] >= 3 && lx[k] <= 5 && ly[k] >= 1 && ly[k] <= 3) ? 8'hFF : 8'h00;
            checks++;
            if (od[k+3] !== e) begin failures++; $display("FAIL modechg dilate px(%0d,%0d) got=%h exp=%h", lx[k], ly[k], od[k+3], e); end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_row [0:9];
        exp_row = '{8'hA0, 8'hA0, 8'hA0, 8'h90, 8'h80, 8'h70, 8'h60, 8'h50, 8'h20, 8'h10};
        for (int x = 0; x < 10; x++) img[0][x] = 8'(8'hA0 - 16 * x);
        drive_frame(1, 10, 2'b10, 2'b10);
        for (int k = 0; k + 3 < n; k++) if (la[k]) begin
            checks++;
            if (od[k+3] !== exp_row[lx[k]]) begin
                failures++;
                $display("FAIL overflow px%0d got=%h exp=%h", lx[k], od[k+3], exp_row[lx[k]]);
            end
            if (lx[k] == 7) begin
                checks++;
                if (oerr[k] !== 1'b0) begin failures++; $display("FAIL overflow err_early got=%b exp=0", oerr[k]); end
            end
            if (lx[k] == 9) begin
                checks++;
                if (oerr[k] !== 1'b1) begin failures++; $display("FAIL overflow err_set got=%b exp=1", oerr[k]); end
            end
        end
        checks++;
        if (err_line_overflow !== 1'b1) begin failures++; $display("FAIL overflow err_sticky got=%b exp=1", err_line_overflow); end

        // Reset asserted and released in the middle of an active line.
        n = 0;
        for (int x = 0; x < 6; x++) step(1, 0, 0, 8'h55, x, 0);
        #2 rst = 1'b0;
        #1;
        checks += 4;
        if (out_active !== 1'b0) begin failures++; $display("FAIL midreset out_active got=%b exp=0", out_active); end
        if (out_data !== 8'h00) begin failures++; $display("FAIL midreset out_data got=%h exp=00", out_data); end
        if (cur_mode !== 2'b00) begin failures++; $display("FAIL midreset cur_mode got=%b exp=00", cur_mode); end
        if (err_line_overflow !== 1'b0) begin failures++; $display("FAIL midreset err got=%b exp=0", err_line_overflow); end
        #1 rst = 1'b1;
        for (int x = 0; x < 6; x++) step(1, 0, 0, 8'h55, x, 0);
        for (int b = 0; b < 4; b++) step(0, 0, 0, 8'h00, -1, -1);
        checks++;
        if (err_line_overflow !== 1'b0) begin failures++; $display("FAIL midreset no_spurious_ovf got=%b exp=0", err_line_overflow); end
    endtask

    initial begin
        n = 0;
        test_reset();
        test_bypass();
        test_dilate();
        test_erode();
        test_gradient();
        test_mode_change();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
